page_walker: RTL and testbench

PAGE_WALKER -- requirements
Module: page_walker

---
 rtl/tlb_pkg.sv | 24 ++
 rtl/pte_decode.sv | 55 +++++
 rtl/page_walker.sv | 149 ++++++++++++++
 tb/tb_page_walker.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// tlb_pkg -- definitions shared by the page-table walker and the
// set-associative TLB: address-width defaults, PTE field positions and the
// walker state encoding.
package tlb_pkg;

  localparam int SADDR_DEF = 64;  // virtual/physical address width
  localparam int SPAGE_DEF = 12;  // page-offset width
  localparam int SPCID_DEF = 12;  // process-context identifier width

  // PTE layout: bit0 valid, bit1 leaf, PPN in [SADDR-1:SPAGE]
  localparam int PTE_W        = 64;
  localparam int PTE_V_BIT    = 0;
  localparam int PTE_LEAF_BIT = 1;
  localparam int PTE_PPN_LSB  = SPAGE_DEF;
  localparam int PTE_PPN_MSB  = SADDR_DEF - 1;

  typedef enum logic [1:0] {
    WALK_IDLE = 2'd0,
    WALK_REQ  = 2'd1,
    WALK_WAIT = 2'd2,
    WALK_DONE = 2'd3
  } walk_state_e;

endpackage

// File: rtl/pte_decode.sv
// pte_decode -- combinational decode of one page-table entry at a given
// walk level.
//   pte_i      : PTE word returned by memory
//   level_i    : level the PTE was read from (0 = last level)
//   va_i       : virtual address being translated
//   next_ppn_o : PPN of the next-level table (valid when descend_o)
//   leaf_pa_o  : translated page base for a leaf at this level
//   fault_o    : invalid PTE, non-leaf at level 0, or misaligned superpage
//   descend_o  : valid non-leaf above level 0, walk continues
module pte_decode import tlb_pkg::*; #(
  parameter int SADDR = SADDR_DEF,
  parameter int SPAGE = SPAGE_DEF,
  parameter int SIDX  = 9,
  parameter int LW    = 2
) (
  input  logic [PTE_W-1:0]       pte_i,
  input  logic [LW-1:0]          level_i,
  input  logic [SADDR-1:0]       va_i,
  output logic [SADDR-SPAGE-1:0] next_ppn_o,
  output logic [SADDR-1:0]       leaf_pa_o,
  output logic                   fault_o,
  output logic                   descend_o
);

  localparam int PPNW = SADDR - SPAGE;

  logic            pte_v;
  logic            pte_leaf;
  logic [PPNW-1:0] pte_ppn;
  logic [PPNW-1:0] va_vpn;
  logic [PPNW-1:0] lo_mask;
  logic [PPNW-1:0] pa_ppn;
  logic            misaligned;
  logic            unused_bits;

  // Reserved PTE bits and the page offset of the VA play no part here.
  assign unused_bits = ^{pte_i[SPAGE-1:2], va_i[SPAGE-1:0]};

  always_comb begin
    pte_v      = pte_i[PTE_V_BIT];
    pte_leaf   = pte_i[PTE_LEAF_BIT];
    pte_ppn    = pte_i[SADDR-1:SPAGE];
    va_vpn     = va_i[SADDR-1:SPAGE];
    // A leaf at level L maps 2^(SIDX*L) pages: the low SIDX*L PPN bits
    // come from the VA and must be zero in the PTE.
    lo_mask    = (PPNW'(1) << (SIDX * int'(level_i))) - PPNW'(1);
    misaligned = |(pte_ppn & lo_mask);
    pa_ppn     = (pte_ppn & ~lo_mask) | (va_vpn & lo_mask);
    next_ppn_o = pte_ppn;
    leaf_pa_o  = {pa_ppn, {SPAGE{1'b0}}};
    descend_o  = pte_v && !pte_leaf && (level_i != '0);
    fault_o    = !pte_v || (!pte_leaf && (level_i == '0)) || (pte_leaf && misaligned);
  end

endmodule

// File: rtl/page_walker.sv
// page_walker -- multi-level page-table walker serving TLB misses.
// One walk at a time; each level issues a single PTE read.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : miss request handshake (ready only when idle)
//   req_va, req_pcid      : missing virtual address and its PCID
//   root_ppn              : root table PPN, sampled at acceptance
//   mem_req_valid/ready   : PTE read request handshake
//   mem_req_addr          : PTE byte address
//   mem_resp_valid/data   : PTE read data, single-cycle pulse
//   resp_valid/ready      : walk result handshake
//   resp_pa, resp_fault   : translated page base (zero on fault), fault flag
//   resp_va, resp_pcid    : echo of the accepted request
module page_walker import tlb_pkg::*; #(
  parameter int SADDR  = SADDR_DEF,
  parameter int SPAGE  = SPAGE_DEF,
  parameter int SPCID  = SPCID_DEF,
  parameter int LEVELS = 3,
  parameter int SIDX   = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SADDR-1:0]       req_va,
  input  logic [SPCID-1:0]       req_pcid,
  input  logic [SADDR-SPAGE-1:0] root_ppn,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [SADDR-1:0]       mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [63:0]            mem_resp_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [SADDR-1:0]       resp_pa,
  output logic [SADDR-1:0]       resp_va,
  output logic [SPCID-1:0]       resp_pcid,
  output logic                   resp_fault
);

  localparam int PPNW = SADDR - SPAGE;
  localparam int LW   = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam logic [LW-1:0] TOP_LEVEL = LW'(LEVELS - 1);

  walk_state_e      state_q, state_d;
  logic [SADDR-1:0] va_q, va_d;
  logic [SPCID-1:0] pcid_q, pcid_d;
  logic [PPNW-1:0]  ppn_q, ppn_d;
  logic [LW-1:0]    level_q, level_d;
  logic [SADDR-1:0] pa_q, pa_d;
  logic             fault_q, fault_d;

  logic [PPNW-1:0]  dec_next_ppn;
  logic [SADDR-1:0] dec_leaf_pa;
  logic             dec_fault;
  logic             dec_descend;
  logic [SIDX-1:0]  vpn_idx;

  pte_decode #(
    .SADDR (SADDR),
    .SPAGE (SPAGE),
    .SIDX  (SIDX),
    .LW    (LW)
  ) u_pte_decode (
    .pte_i      (mem_resp_data),
    .level_i    (level_q),
    .va_i       (va_q),
    .next_ppn_o (dec_next_ppn),
    .leaf_pa_o  (dec_leaf_pa),
    .fault_o    (dec_fault),
    .descend_o  (dec_descend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WALK_IDLE;
      va_q    <= '0;
      pcid_q  <= '0;
      ppn_q   <= '0;
      level_q <= '0;
      pa_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      va_q    <= va_d;
      pcid_q  <= pcid_d;
      ppn_q   <= ppn_d;
      level_q <= level_d;
      pa_q    <= pa_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    va_d    = va_q;
    pcid_d  = pcid_q;
    ppn_d   = ppn_q;
    level_d = level_q;
    pa_d    = pa_q;
    fault_d = fault_q;
    case (state_q)
      WALK_IDLE: begin
        if (req_valid) begin
          va_d    = req_va;
          pcid_d  = req_pcid;
          ppn_d   = root_ppn;
          level_d = TOP_LEVEL;
          state_d = WALK_REQ;
        end
      end
      WALK_REQ: begin
        if (mem_req_ready) state_d = WALK_WAIT;
      end
      WALK_WAIT: begin
        if (mem_resp_valid) begin
          // descend is only raised above level 0, so level never wraps
          if (dec_descend) begin
            ppn_d   = dec_next_ppn;
            level_d = level_q - LW'(1);
            state_d = WALK_REQ;
          end else begin
            fault_d = dec_fault;
            pa_d    = dec_fault ? '0 : dec_leaf_pa;
            state_d = WALK_DONE;
          end
        end
      end
      WALK_DONE: begin
        if (resp_ready) state_d = WALK_IDLE;
      end
      default: state_d = WALK_IDLE;
    endcase
  end

  // PTE address: table base plus 8-byte slot selected by this level's VPN field
  always_comb begin
    vpn_idx      = SIDX'(va_q >> (SPAGE + SIDX * int'(level_q)));
    mem_req_addr = {ppn_q, {SPAGE{1'b0}}} + (SADDR'(vpn_idx) << 3);
  end

  assign req_ready     = (state_q == WALK_IDLE);
  assign mem_req_valid = (state_q == WALK_REQ);
  assign resp_valid    = (state_q == WALK_DONE);
  assign resp_pa       = pa_q;
  assign resp_fault    = fault_q;
  assign resp_va       = va_q;
  assign resp_pcid     = pcid_q;

endmodule

// File: tb/tb_page_walker.sv
`timescale 1ns/1ps
module tb_page_walker;

  localparam int SADDR  = 64;
  localparam int SPAGE  = 12;
  localparam int SPCID  = 12;
  localparam int LEVELS = 3;
  localparam int SIDX   = 9;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   req_valid;
  logic                   req_ready;
  logic [SADDR-1:0]       req_va;
  logic [SPCID-1:0]       req_pcid;
  logic [SADDR-SPAGE-1:0] root_ppn;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [SADDR-1:0]       mem_req_addr;
  logic                   mem_resp_valid;
  logic [63:0]            mem_resp_data;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [SADDR-1:0]       resp_pa;
  logic [SADDR-1:0]       resp_va;
  logic [SPCID-1:0]       resp_pcid;
  logic                   resp_fault;

  always #5 clk = ~clk;

  page_walker #(
    .SADDR(SADDR), .SPAGE(SPAGE), .SPCID(SPCID), .LEVELS(LEVELS), .SIDX(SIDX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_va         (req_va),
    .req_pcid       (req_pcid),
    .root_ppn       (root_ppn),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_pa        (resp_pa),
    .resp_va        (resp_va),
    .resp_pcid      (resp_pcid),
    .resp_fault     (resp_fault)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // PTE returned for the k-th read of the current walk
  logic [63:0] pte_tab [0:3];
  logic [63:0] rd_addr [0:7];
  int          n_reads;
  int          n_results;
  int          latency;
  logic        addr_unstable;
  logic        resp_unstable;
  logic        rdy_seen;
  logic [63:0] got_pa;
  logic [63:0] got_va;
  logic [11:0] got_pcid;
  logic        got_fault;

  localparam logic [63:0] VA_A = 64'h0000_0040_0020_3ABC;

  function automatic logic [63:0] mk_pte(input logic [51:0] ppn, input logic v, input logic leaf);
    return {ppn, 10'b0, leaf, v};
  endfunction

  // Drives one walk: accepts the request, serves PTE reads from pte_tab with
  // optional stalls, records addresses and the result, then retires it.
  task automatic run_walk(input logic [63:0] va, input logic [11:0] pcid, input logic [51:0] root,
                          input int req_stall, input int resp_stall, input bit busy);
    int          cyc;
    int          stall_cnt;
    bit          pending;
    logic [63:0] first_addr;
    n_reads = 0; n_results = 0; latency = -1;
    addr_unstable = 1'b0; resp_unstable = 1'b0; rdy_seen = 1'b0;
    got_pa = 'x; got_va = 'x; got_pcid = 'x; got_fault = 1'bx;
    for (int i = 0; i < 8; i++) rd_addr[i] = '0;
    cyc = 0; stall_cnt = 0; pending = 0; first_addr = '0;
    @(negedge clk);
    req_valid = 1'b1; req_va = va; req_pcid = pcid; root_ppn = root;
    mem_req_ready = 1'b1; resp_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    if (busy) begin
      req_va = ~va; req_pcid = ~pcid;
    end else begin
      req_valid = 1'b0;
    end
    while (resp_valid !== 1'b1 && cyc < 300) begin
      if (req_ready === 1'b1) rdy_seen = 1'b1;
      mem_resp_valid = 1'b0;
      if (pending) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = (n_reads >= 1 && n_reads <= 4) ? pte_tab[n_reads-1] : 64'h0;
        pending = 0;
      end
      mem_req_ready = 1'b1;
      if (mem_req_valid === 1'b1) begin
        if (n_reads == 0 && stall_cnt < req_stall) begin
          mem_req_ready = 1'b0;
          if (stall_cnt == 0) first_addr = mem_req_addr;
          else if (mem_req_addr !== first_addr) addr_unstable = 1'b1;
          stall_cnt++;
        end else begin
          if (n_reads == 0 && stall_cnt > 0 && mem_req_addr !== first_addr) addr_unstable = 1'b1;
          if (n_reads < 8) rd_addr[n_reads] = mem_req_addr;
          n_reads++;
          pending = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    req_valid      = 1'b0;
    latency        = cyc;
    if (resp_valid === 1'b1) begin
      n_results = 1;
      got_pa = resp_pa; got_fault = resp_fault; got_va = resp_va; got_pcid = resp_pcid;
      for (int i = 0; i < resp_stall; i++) begin
        @(negedge clk);
        if (req_ready === 1'b1) rdy_seen = 1'b1;
        if (resp_valid !== 1'b1 || resp_pa !== got_pa || resp_fault !== got_fault ||
            resp_va !== got_va || resp_pcid !== got_pcid) resp_unstable = 1'b1;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (resp_valid === 1'b1) n_results++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL rst_mem_req_valid: got %b want 0", mem_req_valid); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_fault !== 1'b0) $display("FAIL rst_resp_fault: got %b want 0", resp_fault); else n_pass++;
    n_checks++; if (resp_pa !== 64'h0) $display("FAIL rst_resp_pa: got %h want 0", resp_pa); else n_pass++;
    n_checks++; if (resp_va !== 64'h0) $display("FAIL rst_resp_va: got %h want 0", resp_va); else n_pass++;
    n_checks++; if (resp_pcid !== 12'h0) $display("FAIL rst_resp_pcid: got %h want 0", resp_pcid); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_idle_after: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_walk3();
    pte_tab[0] = mk_pte(52'h200, 1'b1, 1'b0);
    pte_tab[1] = mk_pte(52'h300, 1'b1, 1'b0);
    pte_tab[2] = mk_pte(52'h7777, 1'b1, 1'b1);
    run_walk(VA_A, 12'h5A5, 52'h100, 0, 0, 1'b0);
    // VPN fields of VA_A: level2 = 0x100, level1 = 0x001, level0 = 0x003
    n_checks++; if (n_reads !== 3) $display("FAIL walk3_reads: got %0d want 3", n_reads); else n_pass++;
    n_checks++; if (rd_addr[0] !== 64'h100800) $display("FAIL walk3_addr0: got %h want 100800", rd_addr[0]); else n_pass++;
    n_checks++; if (rd_addr[1] !== 64'h200008) $display("FAIL walk3_addr1: got %h want 200008", rd_addr[1]); else n_pass++;
    n_checks++; if (rd_addr[2] !== 64'h300018) $display("FAIL walk3_addr2: got %h want 300018", rd_addr[2]); else n_pass++;
    n_checks++; if (got_pa !== 64'h7777000) $display("FAIL walk3_pa: got %h want 7777000", got_pa); else n_pass++;
    n_checks++; if (got_fault !== 1'b0) $display("FAIL walk3_fault: got %b want 0", got_fault); else n_pass++;
    n_checks++; if (got_va !== VA_A) $display("FAIL walk3_va: got %h want %h", got_va, VA_A); else n_pass++;
    n_checks++; if (got_pcid !== 12'h5A5) $display("FAIL walk3_pcid: got %h want 5a5", got_pcid); else n_pass++;
    n_checks++; if (latency !== 6) $display("FAIL walk3_latency: got %0d want 6", latency); else n_pass++;
    n_checks++; if (n_results !== 1) $display("FAIL walk3_results: got %0d want 1", n_results); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL walk3_idle: got %b want 1", req_ready); else n_pass++;
    // all three VPN fields equal to 1, 1, 3
    run_walk(64'h0000_0000_4020_3ABC, 12'h001, 52'h100, 0, 0, 1'b0);
    n_checks++; if (rd_addr[0] !== 64'h100008) $display("FAIL walk3b_addr0: got %h want 100008", rd_addr[0]); else n_pass++;
    n_checks++; if (got_pa !== 64'h7777000) $display("FAIL walk3b_pa: got %h want 7777000", got_pa); else n_pass++;
  endtask

  task automatic test_invalid_l1();
    pte_tab[0] = mk_pte(52'h200, 1'b1, 1'b0);
    pte_tab[1] = mk_pte(52'h999, 1'b0, 1'b1);
    run_walk(VA_A, 12'h00C, 52'h100, 0, 0, 1'b0);
    n_checks++; if (n_reads !== 2) $display("FAIL inval_reads: got %0d want 2", n_reads); else n_pass++;
    n_checks++; if (rd_addr[1] !== 64'h200008) $display("FAIL inval_addr1: got %h want 200008", rd_addr[1]); else n_pass++;
    n_checks++; if (got_fault !== 1'b1) $display("FAIL inval_fault: got %b want 1", got_fault); else n_pass++;
    n_checks++; if (got_pa !== 64'h0) $display("FAIL inval_pa: got %h want 0", got_pa); else n_pass++;
    n_checks++; if (n_results !== 1) $display("FAIL inval_results: got %0d want 1", n_results); else n_pass++;
  endtask

  task automatic test_superpage();
    pte_tab[0] = mk_pte(52'h200, 1'b1, 1'b0);
    pte_tab[1] = mk_pte(52'h40200, 1'b1, 1'b1);
    run_walk(64'h0000_0000_0000_5123, 12'h0AB, 52'h100, 0, 0, 1'b0);
    n_checks++; if (n_reads !== 2) $display("FAIL super_reads: got %0d want 2", n_reads); else n_pass++;
    n_checks++; if (rd_addr[0] !== 64'h100000) $display("FAIL super_addr0: got %h want 100000", rd_addr[0]); else n_pass++;
    n_checks++; if (rd_addr[1] !== 64'h200000) $display("FAIL super_addr1: got %h want 200000", rd_addr[1]); else n_pass++;
    n_checks++; if (got_pa !== 64'h40205000) $display("FAIL super_pa: got %h want 40205000", got_pa); else n_pass++;
    n_checks++; if (got_fault !== 1'b0) $display("FAIL super_fault: got %b want 0", got_fault); else n_pass++;
    n_checks++; if (latency !== 4) $display("FAIL super_latency: got %0d want 4", latency); else n_pass++;
    pte_tab[1] = mk_pte(52'h40201, 1'b1, 1'b1);
    run_walk(64'h0000_0000_0000_5123, 12'h0AB, 52'h100, 0, 0, 1'b0);
    n_checks++; if (got_fault !== 1'b1) $display("FAIL misalign_fault: got %b want 1", got_fault); else n_pass++;
    n_checks++; if (got_pa !== 64'h0) $display("FAIL misalign_pa: got %h want 0", got_pa); else n_pass++;
  endtask

  task automatic test_stall();
    pte_tab[0] = mk_pte(52'h200, 1'b1, 1'b0);
    pte_tab[1] = mk_pte(52'h300, 1'b1, 1'b0);
    pte_tab[2] = mk_pte(52'h7777, 1'b1, 1'b1);
    run_walk(VA_A, 12'h0F0, 52'h100, 5, 3, 1'b1);
    n_checks++; if (addr_unstable !== 1'b0) $display("FAIL stall_addr_stable: got %b want 0", addr_unstable); else n_pass++;
    n_checks++; if (resp_unstable !== 1'b0) $display("FAIL stall_resp_stable: got %b want 0", resp_unstable); else n_pass++;
    n_checks++; if (rdy_seen !== 1'b0) $display("FAIL stall_req_ready_low: got %b want 0", rdy_seen); else n_pass++;
    n_checks++; if (n_results !== 1) $display("FAIL stall_results: got %0d want 1", n_results); else n_pass++;
    n_checks++; if (n_reads !== 3) $display("FAIL stall_reads: got %0d want 3", n_reads); else n_pass++;
    n_checks++; if (rd_addr[0] !== 64'h100800) $display("FAIL stall_addr0: got %h want 100800", rd_addr[0]); else n_pass++;
    n_checks++; if (got_pa !== 64'h7777000) $display("FAIL stall_pa: got %h want 7777000", got_pa); else n_pass++;
    n_checks++; if (got_va !== VA_A) $display("FAIL stall_va_echo: got %h want %h", got_va, VA_A); else n_pass++;
    n_checks++; if (got_pcid !== 12'h0F0) $display("FAIL stall_pcid_echo: got %h want 0f0", got_pcid); else n_pass++;
    n_checks++; if (latency !== 11) $display("FAIL stall_latency: got %0d want 11", latency); else n_pass++;
  endtask

  task automatic test_nonleaf_l0();
    pte_tab[0] = mk_pte(52'h200, 1'b1, 1'b0);
    pte_tab[1] = mk_pte(52'h300, 1'b1, 1'b0);
    pte_tab[2] = mk_pte(52'h400, 1'b1, 1'b0);
    run_walk(VA_A, 12'h123, 52'h100, 0, 0, 1'b0);
    n_checks++; if (n_reads !== 3) $display("FAIL nl0_reads: got %0d want 3", n_reads); else n_pass++;
    n_checks++; if (rd_addr[2] !== 64'h300018) $display("FAIL nl0_addr2: got %h want 300018", rd_addr[2]); else n_pass++;
    n_checks++; if (got_fault !== 1'b1) $display("FAIL nl0_fault: got %b want 1", got_fault); else n_pass++;
    n_checks++; if (got_pa !== 64'h0) $display("FAIL nl0_pa: got %h want 0", got_pa); else n_pass++;
  endtask

  task automatic test_reset_mid_walk();
    logic bad_valid;
    logic bad_ready;
    @(negedge clk);
    req_valid = 1'b1; req_va = VA_A; req_pcid = 12'h777; root_ppn = 52'h100; mem_req_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL rmid_in_wait: got %b want 0", mem_req_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rmid_req_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (resp_va !== 64'h0) $display("FAIL rmid_resp_va: got %h want 0", resp_va); else n_pass++;
    n_checks++; if (resp_pcid !== 12'h0) $display("FAIL rmid_resp_pcid: got %h want 0", resp_pcid); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = mk_pte(52'h7777, 1'b1, 1'b1);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    bad_valid = 1'b0; bad_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0) bad_valid = 1'b1;
      if (req_ready !== 1'b1) bad_ready = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (bad_valid !== 1'b0) $display("FAIL rmid_stale_ignored: got %b want 0", bad_valid); else n_pass++;
    n_checks++; if (bad_ready !== 1'b0) $display("FAIL rmid_stays_idle: got %b want 0", bad_ready); else n_pass++;
    pte_tab[0] = mk_pte(52'h200, 1'b1, 1'b0);
    pte_tab[1] = mk_pte(52'h300, 1'b1, 1'b0);
    pte_tab[2] = mk_pte(52'h7777, 1'b1, 1'b1);
    run_walk(VA_A, 12'h321, 52'h100, 0, 0, 1'b0);
    n_checks++; if (n_reads !== 3) $display("FAIL rmid_new_reads: got %0d want 3", n_reads); else n_pass++;
    n_checks++; if (got_pa !== 64'h7777000) $display("FAIL rmid_new_pa: got %h want 7777000", got_pa); else n_pass++;
    n_checks++; if (got_fault !== 1'b0) $display("FAIL rmid_new_fault: got %b want 0", got_fault); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_va = '0; req_pcid = '0; root_ppn = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) pte_tab[i] = '0;
    test_reset();
    test_walk3();
    test_invalid_l1();
    test_superpage();
    test_stall();
    test_nonleaf_l0();
    test_reset_mid_walk();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
